systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL take parameter W, default matrix_pkg::indata_size (8), the element width.
REQ-002 SHALL take parameter N, default matrix_pkg::array_dim (4), the systolic array dimension.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  load beat offered.
REQ-006 in_ready  output  1  feeder accepts a load beat.
REQ-007 in_a_col  input  N*W  signed column k of A; element i at bits [i*W +: W].
REQ-008 in_b_row  input  N*W  signed row k of B; element j at bits [j*W +: W].
REQ-009 a_edge  output  N*W  signed, registered; lane i drives in_a of array PE(i,0).
REQ-010 b_edge  output  N*W  signed, registered; lane j drives in_b of array PE(0,j).
REQ-011 push  output  N*N  registered; bit i*N+j drives the push input of PE(i,j).
REQ-012 tile_done  output  1  single-cycle pulse: every out_c in the array holds the final C[i][j].

Function
REQ-013 A beat SHALL transfer only in a cycle with in_valid=1 and in_ready=1; beat k (0..N-1) SHALL be stored as A[*][k] and B[k][*].
REQ-014 The FSM SHALL have exactly two states: LOAD (in_ready=1) and STREAM (in_ready=0).
REQ-015 LOAD SHALL count accepted beats; acceptance of beat N-1 SHALL transition to STREAM.
REQ-016 In STREAM, the stream counter c SHALL be 0 in the first STREAM cycle (the cycle after the last beat is accepted) and increment by 1 per cycle.
REQ-017 At stream cycle c, a_edge lane i SHALL equal A[i][c-i] when 0<=c-i<=N-1, else 0.
REQ-018 At stream cycle c, b_edge lane j SHALL equal B[c-j][j] when 0<=c-j<=N-1, else 0.
REQ-019 At stream cycle c, push bit i*N+j SHALL be 1 iff c==i+j; all push bits SHALL be 0 in LOAD.
REQ-020 tile_done SHALL be 1 exactly at c==3N-2; the next cycle SHALL be LOAD, with the beat counter at 0.
REQ-021 In LOAD, a_edge and b_edge SHALL be 0.
REQ-022 in_valid during STREAM SHALL be ignored and SHALL NOT alter stored data.
REQ-023 Load gaps (in_valid=0) SHALL stall the beat count only; no timeout.
REQ-024 No arithmetic SHALL be performed on data: stored values pass through bit-exact and signed; zero padding is exact 0.
REQ-025 The earliest next tile SHALL be accepted in the cycle after tile_done, giving a minimum tile period of N+3N-1 cycles.

Reset
REQ-026 Reset assertion SHALL immediately set the state to LOAD, the beat counter and c to 0, and a_edge, b_edge, push and tile_done to 0, independent of clk.
REQ-027 After reset, in_ready SHALL be 1 and stored tile contents SHALL be don't-care; a partial load or stream in progress at reset SHALL be discarded.

Structure
REQ-028 indata_size and array_dim SHALL reside in matrix_pkg; the FSM state enum SHALL be a matrix_pkg typedef.
REQ-029 The N x N A and B storage SHALL be one sub-module, feeder_tile_buffer (write port indexed by beat, per-lane read port indexed by c-lane); the FSM and push generation SHALL stay in systolic_feeder.

Verification (N=4, W=8, bench includes a behavioural PE-array model)
REQ-030 Reset, then release -> in_ready=1; a_edge, b_edge, push and tile_done all 0.
REQ-031 Load A=identity, B=1..16 row-major -> a_edge lane0=1 at c=0; push bit0 at c=0; push bit15 at c=6; tile_done at c=10; model C equals B.
REQ-032 A all -128, B all 127 -> lane values bit-exact (0x80/0x7F); every C = -65024.
REQ-033 Four beats with 1-3 cycle in_valid bubbles between them, in_valid held during STREAM -> exactly 4 handshakes; in_ready=0 for c=0..10; stored data unchanged.
REQ-034 Reset asserted mid-cycle at c=3 -> outputs 0 before the next edge; a subsequent full tile yields a correct C.
REQ-035 Two tiles back-to-back with in_valid held high -> the first beat of the second tile is accepted in the cycle after tile_done; the second C is correct with no residue from the first tile.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared sizing constants and FSM state type for the systolic array feeder.
package matrix_pkg;

   localparam int indata_size = 8;
   localparam int array_dim   = 4;

   typedef enum logic {
      LOAD   = 1'b0,
      STREAM = 1'b1
   } feeder_state_t;

   // Skew offset: which beat a lane reads at a given stream cycle.
   function automatic int lane_offset(input int c, input int lane);
      return c - lane;
   endfunction

endpackage

// File: rtl/feeder_tile_buffer.sv
// N x N storage for one A/B tile: written one beat per cycle, read out skewed per lane.
module feeder_tile_buffer
   import matrix_pkg::*;
#(
   parameter int W  = indata_size,
   parameter int N  = array_dim,
   parameter int BW = 2,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [BW-1:0] wr_beat,
   input  logic [N*W-1:0] wr_a_col,
   input  logic [N*W-1:0] wr_b_row,
   input  logic          rd_en,
   input  logic [CW-1:0] rd_c,
   output logic [N*W-1:0] rd_a,
   output logic [N*W-1:0] rd_b
);

   logic signed [W-1:0] a_mem [N][N];
   logic signed [W-1:0] b_mem [N][N];
   int d;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < N; i++) begin
            a_mem[i][wr_beat] <= wr_a_col[i*W +: W];
            b_mem[wr_beat][i] <= wr_b_row[i*W +: W];
         end
      end
   end

   // Lanes whose skewed beat index falls outside the tile are padded with exact zero.
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      d    = 0;
      for (int lane = 0; lane < N; lane++) begin
         d = lane_offset(int'(rd_c), lane);
         if (rd_en && d >= 0 && d < N) begin
            rd_a[lane*W +: W] = a_mem[lane][d[BW-1:0]];
            rd_b[lane*W +: W] = b_mem[d[BW-1:0]][lane];
         end
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Loads an A/B tile beat by beat, then streams skewed edges and per-PE push strobes.
module systolic_feeder
   import matrix_pkg::*;
#(
   parameter int W = indata_size,
   parameter int N = array_dim
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [N*W-1:0] in_a_col,
   input  logic signed [N*W-1:0] in_b_row,
   output logic signed [N*W-1:0] a_edge,
   output logic signed [N*W-1:0] b_edge,
   output logic [N*N-1:0]      push,
   output logic                tile_done
);

   localparam int BW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(3*N - 1);
   localparam logic [BW-1:0] B_LAST = BW'(N - 1);
   localparam logic [CW-1:0] C_LAST = CW'(3*N - 2);

   feeder_state_t  state, nxt_state;
   logic [BW-1:0]  beat, nxt_beat;
   logic [CW-1:0]  c, nxt_c;
   logic           accept, rd_en, nxt_done;
   logic [N*W-1:0] rd_a, rd_b;
   logic [N*N-1:0] nxt_push;

   assign in_ready = (state == LOAD);
   assign accept   = in_valid && in_ready;

   always_comb begin
      nxt_state = state;
      nxt_beat  = beat;
      nxt_c     = c;
      case (state)
         LOAD: begin
            if (accept) begin
               if (beat == B_LAST) begin
                  nxt_state = STREAM;
                  nxt_beat  = '0;
                  nxt_c     = '0;
               end else begin
                  nxt_beat = beat + 1'b1;
               end
            end
         end
         STREAM: begin
            if (c == C_LAST) begin
               nxt_state = LOAD;
               nxt_c     = '0;
            end else begin
               nxt_c = c + 1'b1;
            end
         end
      endcase
   end

   // Outputs are registered, so they are computed from the cycle being entered.
   assign rd_en    = (nxt_state == STREAM);
   assign nxt_done = rd_en && (nxt_c == C_LAST);

   always_comb begin
      nxt_push = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (rd_en && int'(nxt_c) == i + j)
               nxt_push[i*N + j] = 1'b1;
   end

   feeder_tile_buffer #(.W(W), .N(N), .BW(BW), .CW(CW)) u_buf (
      .clk      (clk),
      .wr_en    (accept),
      .wr_beat  (beat),
      .wr_a_col (in_a_col),
      .wr_b_row (in_b_row),
      .rd_en    (rd_en),
      .rd_c     (nxt_c),
      .rd_a     (rd_a),
      .rd_b     (rd_b)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= LOAD;
         beat      <= '0;
         c         <= '0;
         a_edge    <= '0;
         b_edge    <= '0;
         push      <= '0;
         tile_done <= 1'b0;
      end else begin
         state     <= nxt_state;
         beat      <= nxt_beat;
         c         <= nxt_c;
         a_edge    <= rd_a;
         b_edge    <= rd_b;
         push      <= nxt_push;
         tile_done <= nxt_done;
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder with a behavioural output-stationary PE-array model.
module tb_systolic_feeder;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int NC = 3*N - 1;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] in_a_col, in_b_row;
   logic [N*W-1:0] a_edge, b_edge;
   logic [N*N-1:0] push;
   logic           tile_done;

   int checks = 0;
   int failures = 0;
   int hs = 0;
   int hs0;
   int w0;

   logic signed [W-1:0] ma [2][N][N];
   logic signed [W-1:0] mb [2][N][N];
   logic signed [W-1:0] pa [N][N], pb [N][N];
   logic signed [W-1:0] ca [N][N], cb [N][N];
   int acc [N][N];

   typedef struct {
      int          c;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] p;
      logic        d;
   } vec_t;
   vec_t tbl [NC];

   always #5 clk = ~clk;

   systolic_feeder #(.W(W), .N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a_col  (in_a_col),
      .in_b_row  (in_b_row),
      .a_edge    (a_edge),
      .b_edge    (b_edge),
      .push      (push),
      .tile_done (tile_done)
   );

   // PE(i,j) sees a delayed by j and b delayed by i; push starts a new accumulation.
   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               pa[i][j] = '0; pb[i][j] = '0; acc[i][j] = 0;
            end
      end else begin
         if (in_valid && in_ready) hs++;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               ca[i][j] = (j == 0) ? a_edge[i*W +: W] : pa[i][(j == 0) ? 0 : j-1];
               cb[i][j] = (i == 0) ? b_edge[j*W +: W] : pb[(i == 0) ? 0 : i-1][j];
            end
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               if (push[i*N + j]) acc[i][j] = int'(ca[i][j]) * int'(cb[i][j]);
               else               acc[i][j] = acc[i][j] + int'(ca[i][j]) * int'(cb[i][j]);
            end
         pa = ca;
         pb = cb;
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   function automatic logic [N*W-1:0] pack_col(input int s, input int k);
      logic [N*W-1:0] v;
      for (int i = 0; i < N; i++) v[i*W +: W] = ma[s][i][k];
      return v;
   endfunction

   function automatic logic [N*W-1:0] pack_row(input int s, input int k);
      logic [N*W-1:0] v;
      for (int j = 0; j < N; j++) v[j*W +: W] = mb[s][k][j];
      return v;
   endfunction

   function automatic logic [N*W-1:0] exp_a(input int s, input int c);
      logic [N*W-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         if (c - i >= 0 && c - i < N) v[i*W +: W] = ma[s][i][c-i];
      return v;
   endfunction

   function automatic logic [N*W-1:0] exp_b(input int s, input int c);
      logic [N*W-1:0] v;
      v = '0;
      for (int j = 0; j < N; j++)
         if (c - j >= 0 && c - j < N) v[j*W +: W] = mb[s][c-j][j];
      return v;
   endfunction

   function automatic logic [N*N-1:0] exp_push(input int c);
      logic [N*N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (c == i + j) v[i*N + j] = 1'b1;
      return v;
   endfunction

   function automatic int exp_c(input int s, input int i, input int j);
      int sum;
      sum = 0;
      for (int k = 0; k < N; k++) sum += int'(ma[s][i][k]) * int'(mb[s][k][j]);
      return sum;
   endfunction

   // post: 0 drop valid, 1 hold valid with junk data, 2 hold valid with next slot's beat 0.
   task automatic load_tile(input int s, input bit gaps, input int post, output int wait0);
      int n;
      bit ok;
      wait0 = 0;
      for (int k = 0; k < N; k++) begin
         if (gaps && k > 0)
            repeat ((k % 3) + 1) begin in_valid = 1'b0; @(posedge clk); #1; end
         in_valid = 1'b1;
         in_a_col = pack_col(s, k);
         in_b_row = pack_row(s, k);
         n = 0; ok = 1'b0;
         while (!ok && n < 50) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
            if (!ok) n++;
         end
         if (!ok) chk($sformatf("beat_accept k=%0d", k), longint'(ok), 1);
         if (k == 0) wait0 = n;
      end
      case (post)
         0: in_valid = 1'b0;
         1: begin in_valid = 1'b1; in_a_col = 32'hA5A5_5A5A; in_b_row = 32'h7E81_C33C; end
         default: begin in_valid = 1'b1; in_a_col = pack_col(1-s, 0); in_b_row = pack_row(1-s, 0); end
      endcase
   endtask

   task automatic check_stream(input int s, input bit use_tbl);
      for (int c = 0; c < NC; c++) begin
         @(negedge clk); #1;
         chk($sformatf("in_ready c=%0d", c), longint'(in_ready), 0);
         if (use_tbl) begin
            chk($sformatf("tbl_a c=%0d", tbl[c].c), longint'(a_edge), longint'(tbl[c].a));
            chk($sformatf("tbl_b c=%0d", tbl[c].c), longint'(b_edge), longint'(tbl[c].b));
            chk($sformatf("tbl_push c=%0d", tbl[c].c), longint'(push), longint'(tbl[c].p));
            chk($sformatf("tbl_done c=%0d", tbl[c].c), longint'(tile_done), longint'(tbl[c].d));
         end else begin
            chk($sformatf("a_edge c=%0d", c), longint'(a_edge), longint'(exp_a(s, c)));
            chk($sformatf("b_edge c=%0d", c), longint'(b_edge), longint'(exp_b(s, c)));
            chk($sformatf("push c=%0d", c), longint'(push), longint'(exp_push(c)));
            chk($sformatf("tile_done c=%0d", c), longint'(tile_done), (c == NC-1) ? 1 : 0);
         end
         if (c == NC-1)
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++)
                  chk($sformatf("C[%0d][%0d]", i, j), longint'(acc[i][j]), longint'(exp_c(s, i, j)));
         @(posedge clk); #1;
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_in_ready"}, longint'(in_ready), 1);
      chk({tag, "_a_edge"}, longint'(a_edge), 0);
      chk({tag, "_b_edge"}, longint'(b_edge), 0);
      chk({tag, "_push"}, longint'(push), 0);
      chk({tag, "_tile_done"}, longint'(tile_done), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{0,  32'h0000_0001, 32'h0000_0001, 16'h0001, 1'b0};
      tbl[1]  = '{1,  32'h0000_0000, 32'h0000_0205, 16'h0012, 1'b0};
      tbl[2]  = '{2,  32'h0000_0100, 32'h0003_0609, 16'h0124, 1'b0};
      tbl[3]  = '{3,  32'h0000_0000, 32'h0407_0A0D, 16'h1248, 1'b0};
      tbl[4]  = '{4,  32'h0001_0000, 32'h080B_0E00, 16'h2480, 1'b0};
      tbl[5]  = '{5,  32'h0000_0000, 32'h0C0F_0000, 16'h4800, 1'b0};
      tbl[6]  = '{6,  32'h0100_0000, 32'h1000_0000, 16'h8000, 1'b0};
      tbl[7]  = '{7,  32'h0000_0000, 32'h0000_0000, 16'h0000, 1'b0};
      tbl[8]  = '{8,  32'h0000_0000, 32'h0000_0000, 16'h0000, 1'b0};
      tbl[9]  = '{9,  32'h0000_0000, 32'h0000_0000, 16'h0000, 1'b0};
      tbl[10] = '{10, 32'h0000_0000, 32'h0000_0000, 16'h0000, 1'b1};

      reset = 1'b1; in_valid = 1'b0; in_a_col = '0; in_b_row = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk); #1;
      check_idle("reset");
      @(posedge clk); #1;

      // Identity A, B = 1..16 row-major
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ma[0][i][k] = (i == k) ? 8'sd1 : 8'sd0;
            mb[0][i][k] = 8'(i*4 + k + 1);
         end
      hs0 = hs;
      load_tile(0, 1'b0, 0, w0);
      check_stream(0, 1'b1);
      chk("ident_handshakes", longint'(hs - hs0), 4);
      @(negedge clk); #1;
      check_idle("after_tile");
      @(posedge clk); #1;

      // Extreme signed values
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ma[0][i][k] = -8'sd128;
            mb[0][i][k] = 8'sd127;
         end
      load_tile(0, 1'b0, 0, w0);
      check_stream(0, 1'b0);
      chk("extreme_C33", longint'(acc[3][3]), -65024);
      chk("extreme_C00", longint'(acc[0][0]), -65024);

      // Bubbles between beats, in_valid held with junk during STREAM
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ma[0][i][k] = 8'(i*16 - k*7 - 20);
            mb[0][i][k] = 8'(i*5 - k*9 + 3);
         end
      hs0 = hs;
      load_tile(0, 1'b1, 1, w0);
      check_stream(0, 1'b0);
      chk("bubble_handshakes", longint'(hs - hs0), 4);
      in_valid = 1'b0;

      // Asynchronous reset in the middle of stream cycle 3
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ma[0][i][k] = 8'(i + k + 1);
            mb[0][i][k] = 8'(2*i - k);
         end
      load_tile(0, 1'b0, 0, w0);
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk); #1;
      chk("push_before_reset", longint'(push), 16'h1248);
      reset = 1'b1;
      #1;
      check_idle("midreset");
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ma[0][i][k] = 8'(3*i - 2*k + 7);
            mb[0][i][k] = 8'(-i*11 + k*13 - 40);
         end
      load_tile(0, 1'b0, 0, w0);
      check_stream(0, 1'b0);

      // Two tiles back to back with in_valid held high
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ma[0][i][k] = 8'(100 - 17*i - 9*k);
            mb[0][i][k] = 8'(i*k - 60);
            ma[1][i][k] = 8'(-5*i + 4*k + 1);
            mb[1][i][k] = 8'(7*i + k - 12);
         end
      hs0 = hs;
      load_tile(0, 1'b0, 2, w0);
      check_stream(0, 1'b0);
      chk("b2b_tile1_handshakes", longint'(hs - hs0), 4);
      load_tile(1, 1'b0, 0, w0);
      chk("b2b_first_beat_wait", longint'(w0), 0);
      check_stream(1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
